// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg
// Shared definitions for the MIPS trace buffer: the controller state
// encoding and the width of the per-entry cycle stamp.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } trace_state_t;

    localparam int CYCLE_W = 16;

endpackage

// File: rtl/trace_ram.sv
// trace_ram
// Simple dual-port storage for trace entries: one synchronous write port
// and one synchronous read port with one cycle of read latency.
// The read register only loads when re is high, so rdata holds the last
// value read between reads.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data (valid the cycle after re)
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
// Change-triggered trace capture for a MIPS core. A start pulse clears the
// buffer and opens a capture window of RUN_CYCLES cycles. During the window
// the tuple {instruction, result, watch} is sampled every cycle and stored,
// together with a cycle stamp, on the first cycle and whenever it differs
// from the previous cycle's sample. After the window the block sits in DONE
// and entries can be popped oldest-first.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   pulse: clear buffer, begin a run (beats rd_en)
//   instruction  in   instruction being executed
//   result       in   ALU/write-back result
//   watch        in   watched register value
//   rd_en        in   pop request (honoured only in DONE with count>0)
//   rd_valid     out  one-cycle pulse, the cycle after an accepted pop
//   rd_instr     out  popped instruction
//   rd_result    out  popped result
//   rd_watch     out  popped watch value
//   rd_cycle     out  cycle stamp of the popped entry
//   count        out  number of stored entries
//   overflow     out  sticky: an entry was overwritten or dropped
//   busy         out  state == RUN
//   done         out  state == DONE
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int IW         = 16,
    parameter int DW         = 32,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 36,
    parameter int WRAP       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IW-1:0]            instruction,
    input  logic [DW-1:0]            result,
    input  logic [DW-1:0]            watch,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [IW-1:0]            rd_instr,
    output logic [DW-1:0]            rd_result,
    output logic [DW-1:0]            rd_watch,
    output logic [15:0]              rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = IW + 2 * DW;
    localparam int EW = SW + CYCLE_W;

    localparam logic [CYCLE_W-1:0] LAST_CYC = CYCLE_W'(RUN_CYCLES - 1);
    localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);

    trace_state_t         state, state_nx;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CYCLE_W-1:0]   cyc;
    logic [SW-1:0]        sample, prev_sample;
    logic                 changed, capture, full, wr_en, pop;
    logic                 rd_vld_p1;
    logic                 have_data;
    logic [EW-1:0]        ram_q;

    assign sample = {instruction, result, watch};

    // The first cycle of a run always writes, so prev_sample needs no reset.
    assign changed = (cyc == '0) || (sample != prev_sample);
    assign capture = (state == S_RUN) && !start && changed;
    assign full    = (count == FULL_CNT);
    assign wr_en   = capture && (!full || (WRAP != 0));
    assign pop     = (state == S_DONE) && !start && rd_en && (count != '0);

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (cyc == LAST_CYC) state_nx = S_DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cyc       <= '0;
            overflow  <= 1'b0;
            rd_vld_p1 <= 1'b0;
            have_data <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx == S_RUN);
            done      <= (state_nx == S_DONE);
            rd_vld_p1 <= pop;
            if (pop) begin
                have_data <= 1'b1;
            end

            if (start) begin
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cyc      <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == S_RUN) begin
                    cyc <= cyc + CYCLE_W'(1);
                    if (capture) begin
                        if (full) begin
                            overflow <= 1'b1;
                            // Wrapping: the write lands on the oldest slot,
                            // so the read pointer steps past it.
                            if (WRAP != 0) begin
                                wr_ptr <= wr_ptr + AW'(1);
                                rd_ptr <= rd_ptr + AW'(1);
                            end
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            count  <= count + CW'(1);
                        end
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RUN) begin
            prev_sample <= sample;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({sample, cyc}),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // ram_q holds between pops; have_data masks the uninitialised RAM
    // register so the outputs read zero until the first pop after reset.
    assign rd_valid = rd_vld_p1;
    assign {rd_instr, rd_result, rd_watch, rd_cycle} = have_data ? ram_q : '0;

endmodule

// File: tb/tb_mips_trace_buffer.sv
module tb_mips_trace_buffer;

    localparam int IW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int RC    = 36;

    typedef struct packed {
        logic [IW-1:0] i;
        logic [DW-1:0] r;
        logic [DW-1:0] w;
        logic [15:0]   c;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [IW-1:0] instruction;
    logic [DW-1:0] result, watch;
    logic          st  [3];
    logic          rd  [3];
    logic          vld [3];
    logic [IW-1:0] ri  [3];
    logic [DW-1:0] rr  [3];
    logic [DW-1:0] rw  [3];
    logic [15:0]   rc  [3];
    logic [4:0]    cnt [3];
    logic          ovf [3];
    logic          bsy [3];
    logic          dn  [3];

    mips_trace_buffer u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .instruction(instruction),
        .result(result), .watch(watch), .rd_en(rd[0]), .rd_valid(vld[0]),
        .rd_instr(ri[0]), .rd_result(rr[0]), .rd_watch(rw[0]), .rd_cycle(rc[0]),
        .count(cnt[0]), .overflow(ovf[0]), .busy(bsy[0]), .done(dn[0]));

    mips_trace_buffer #(.WRAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .instruction(instruction),
        .result(result), .watch(watch), .rd_en(rd[1]), .rd_valid(vld[1]),
        .rd_instr(ri[1]), .rd_result(rr[1]), .rd_watch(rw[1]), .rd_cycle(rc[1]),
        .count(cnt[1]), .overflow(ovf[1]), .busy(bsy[1]), .done(dn[1]));

    mips_trace_buffer #(.RUN_CYCLES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .instruction(instruction),
        .result(result), .watch(watch), .rd_en(rd[2]), .rd_valid(vld[2]),
        .rd_instr(ri[2]), .rd_result(rr[2]), .rd_watch(rw[2]), .rd_cycle(rc[2]),
        .count(cnt[2]), .overflow(ovf[2]), .busy(bsy[2]), .done(dn[2]));

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t stim [RC];
    ent_t exp_q [3][$];
    bit   exp_ovf [3];
    ent_t last_pop [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the trace is every sample that differs from its predecessor
    // (plus the first), stamped with its cycle index; a full buffer keeps the
    // newest DEPTH (wrap) or the first DEPTH (no wrap).
    task automatic model(input int k, input int n, input bit wrap);
        ent_t all [$];
        ent_t e;
        all = {};
        for (int j = 0; j < n; j++) begin
            if (j == 0 || stim[j].i != stim[j-1].i || stim[j].r != stim[j-1].r ||
                stim[j].w != stim[j-1].w) begin
                e = stim[j];
                e.c = 16'(j);
                all.push_back(e);
            end
        end
        exp_ovf[k] = (all.size() > DEPTH);
        while (all.size() > DEPTH) begin
            if (wrap) void'(all.pop_front());
            else      void'(all.pop_back());
        end
        exp_q[k] = all;
    endtask

    // mode 0: constant 1234/0/0; mode 1: instruction changes every cycle;
    // mode 2: random field changes with probability pct percent per cycle.
    task automatic fill_stim(input int mode, input int pct);
        ent_t e;
        e.i = IW'($urandom); e.r = $urandom; e.w = $urandom; e.c = '0;
        for (int j = 0; j < RC; j++) begin
            case (mode)
                0: begin e.i = 16'h1234; e.r = '0; e.w = '0; end
                1: e.i = 16'(16'hA000 + j);
                default: begin
                    if ($urandom_range(0, 99) < pct) begin
                        case ($urandom_range(0, 2))
                            0: e.i = IW'($urandom);
                            1: e.r = $urandom;
                            default: e.w = $urandom;
                        endcase
                    end
                end
            endcase
            stim[j] = e;
        end
    endtask

    task automatic drive(input int j);
        instruction = stim[j].i;
        result      = stim[j].r;
        watch       = stim[j].w;
    endtask

    // Runs u0 and u1 together over stim; optionally toggles rd_en during RUN.
    task automatic run01(input bit rnd_rd);
        @(negedge clk);
        st[0] = 1'b1; st[1] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; st[1] = 1'b0;
        chk("busy_after_start", {bsy[0], bsy[1]}, 2'b11);
        for (int j = 0; j < RC; j++) begin
            drive(j);
            rd[0] = rnd_rd ? 1'($urandom) : 1'b0;
            rd[1] = rd[0];
            @(negedge clk);
            chk("no_rd_in_run", {vld[0], vld[1]}, 2'b00);
            chk("done_timing", {dn[0], bsy[0]}, (j == RC - 1) ? 2'b10 : 2'b01);
        end
        rd[0] = 1'b0; rd[1] = 1'b0;
        model(0, RC, 1'b1);
        model(1, RC, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("count_end", 64'(cnt[k]), 64'(exp_q[k].size()));
            chk("overflow_end", 64'(ovf[k]), 64'(exp_ovf[k]));
            chk("done_end", 64'(dn[k]), 64'd1);
        end
    endtask

    // Pops everything the model expects, back to back, then one extra rd_en.
    task automatic drain(input int k);
        ent_t e;
        int   n;
        n = exp_q[k].size();
        for (int p = 0; p < n; p++) begin
            rd[k] = 1'b1;
            @(negedge clk);
            rd[k] = 1'b0;
            e = exp_q[k].pop_front();
            chk("pop_valid", 64'(vld[k]), 64'd1);
            chk("pop_entry", 64'({ri[k], rc[k]}), 64'({e.i, e.c}));
            chk("pop_result", 64'({rr[k], rw[k]}), {e.r, e.w});
            chk("pop_count", 64'(cnt[k]), 64'(n - p - 1));
            last_pop[k] = e;
        end
        rd[k] = 1'b1;
        @(negedge clk);
        rd[k] = 1'b0;
        chk("empty_rd_ignored", 64'(vld[k]), 64'd0);
        chk("empty_count", 64'(cnt[k]), 64'd0);
        if (n > 0) begin
            chk("rd_hold", 64'({ri[k], rc[k]}), 64'({last_pop[k].i, last_pop[k].c}));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = '0; result = '0; watch = '0;
        for (int k = 0; k < 3; k++) begin st[k] = 1'b0; rd[k] = 1'b0; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ctrl", 64'({bsy[k], dn[k], ovf[k], vld[k], cnt[k]}), 64'd0);
            chk("reset_data", 64'({ri[k], rc[k]}), 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_holds", 64'({bsy[0], dn[0], bsy[1], dn[1]}), 64'd0);

        // Constant input: one entry stamped 0.
        fill_stim(0, 0);
        run01(1'b0);
        drain(0);
        drain(1);

        // Instruction changes every cycle: wrap keeps 20..35, no-wrap keeps 0..15.
        fill_stim(1, 0);
        run01(1'b1);
        drain(0);
        drain(1);

        // Random change patterns with stray rd_en during RUN.
        for (int it = 0; it < 3; it++) begin
            fill_stim(2, (it == 0) ? 15 : (it == 1) ? 45 : 90);
            run01(1'b1);
            drain(0);
            drain(1);
        end

        // Reset in the middle of a run.
        fill_stim(2, 50);
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive(j);
            @(negedge clk);
        end
        chk("busy_before_rst", 64'(bsy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 64'({bsy[0], dn[0], ovf[0], vld[0], cnt[0]}), 64'd0);
        chk("rst_async_data", 64'({ri[0], rc[0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        chk("rd_after_rst", 64'({vld[0], bsy[0], dn[0], cnt[0]}), 64'd0);

        // DONE with 5 entries: start and rd_en together, start wins.
        for (int j = 0; j < RC; j++) begin
            stim[j].i = (j < 5) ? 16'(16'h0500 + j) : 16'h0504;
            stim[j].r = 32'h0000_00AA;
            stim[j].w = 32'h0000_00BB;
        end
        run01(1'b0);
        chk("five_entries", 64'(cnt[0]), 64'd5);
        st[0] = 1'b1; rd[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; rd[0] = 1'b0;
        chk("start_beats_rd", 64'({vld[0], bsy[0], cnt[0]}), 64'({1'b0, 1'b1, 5'd0}));
        repeat (RC) @(negedge clk);
        chk("restart_done", 64'({dn[0], cnt[0]}), 64'({1'b1, 5'd1}));

        // RUN_CYCLES=1: single capture, DONE one edge after the start edge.
        stim[0].i = IW'($urandom); stim[0].r = $urandom; stim[0].w = $urandom;
        drive(0);
        @(negedge clk);
        st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        chk("rc1_busy", 64'({bsy[2], dn[2]}), 64'b10);
        @(negedge clk);
        chk("rc1_done", 64'({bsy[2], dn[2], cnt[2]}), 64'({1'b0, 1'b1, 5'd1}));
        model(2, 1, 1'b1);
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
